// File: rtl/seg7_scan_drv.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered value and blank gap per slot.
// Optional LEAD_ZERO_BLANK_EN: suppress leading zero digits (digit 0 always shown).
module seg7_scan_drv #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int NUM_DIG   = 4,
    parameter int BLANK_CYC = 500
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*NUM_DIG-1:0]   data_in,
    input  logic [NUM_DIG-1:0]     dp_in,
    input  logic                   load,
    output logic [7:0]             seg_n,
    output logic [NUM_DIG-1:0]     sel_n,
    output logic                   frame_done
);

    localparam int TICK = CLK_HZ / SCAN_HZ;
    localparam int CW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int IW   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*NUM_DIG-1:0]   pend_val;
    logic [NUM_DIG-1:0]     pend_dp;
    logic                   pend_valid;
    logic [4*NUM_DIG-1:0]   act_val;
    logic [NUM_DIG-1:0]     act_dp;

    logic                   boundary;
    logic                   blank;
    logic [3:0]             nib;
    logic [7:0]             show_seg;
    logic [NUM_DIG-1:0]     show_sel;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign boundary = (cnt == CNT_LAST);

    // With no blank gap the comparison would be constant-false, so drop it entirely.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign blank = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
            assign blank = (cnt < BLANK_LIM);
        end
    endgenerate

    assign nib      = act_val[{idx, 2'b00} +: 4];
    assign show_sel = ~(NUM_DIG'(1) << idx);

`ifdef LEAD_ZERO_BLANK_EN
    logic [NUM_DIG-1:0] lz;
    logic               hi_zero;

    // Walk down from the top digit: a digit is leading-zero while every nibble at or above it is zero.
    always_comb begin
        hi_zero = 1'b1;
        lz      = '0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            hi_zero = hi_zero && (act_val[4*i +: 4] == 4'h0);
            lz[i]   = (i != 0) && hi_zero && !act_dp[i];
        end
    end

    always_comb begin
        show_seg = {~act_dp[idx], hex7(nib)};
        if (lz[idx]) show_seg = 8'hFF;
    end
`else
    always_comb begin
        show_seg = {~act_dp[idx], hex7(nib)};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            act_val    <= '0;
            act_dp     <= '0;
            seg_n      <= 8'hFF;
            sel_n      <= '1;
            frame_done <= 1'b0;
        end else begin
            if (boundary) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // act only moves on a slot boundary; a load landing on the boundary goes straight in.
            if (boundary) begin
                pend_valid <= 1'b0;
                if (load) begin
                    act_val <= data_in;
                    act_dp  <= dp_in;
                end else if (pend_valid) begin
                    act_val <= pend_val;
                    act_dp  <= pend_dp;
                end
            end else if (load) begin
                pend_val   <= data_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end

            if (blank) begin
                seg_n <= 8'hFF;
                sel_n <= '1;
            end else begin
                seg_n <= show_seg;
                sel_n <= show_sel;
            end

            frame_done <= boundary && (idx == IDX_LAST);
        end
    end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Randomized self-checking bench for seg7_scan_drv against a slot/time-based reference model.
module tb_seg7_scan_drv;

    localparam int CLK_HZ    = 1000;
    localparam int SCAN_HZ   = 100;
    localparam int NUM_DIG   = 4;
    localparam int BLANK_CYC = 2;
    localparam int TICK      = CLK_HZ / SCAN_HZ;

    logic                 clk;
    logic                 rst_n;
    logic [4*NUM_DIG-1:0] data_in;
    logic [NUM_DIG-1:0]   dp_in;
    logic                 load;
    logic [7:0]           seg_n;
    logic [NUM_DIG-1:0]   sel_n;
    logic                 frame_done;

    seg7_scan_drv #(
        .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .NUM_DIG(NUM_DIG), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
        .seg_n(seg_n), .sel_n(sel_n), .frame_done(frame_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    // load history since reset: cycle of each load and its {dp, value}
    int          ld_cyc[$];
    logic [19:0] ld_val[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Value shown in slot k is the last load taken strictly before that slot began.
    function automatic logic [19:0] act_for(input int c);
        int slot_start;
        logic [19:0] v;
        slot_start = (c / TICK) * TICK;
        v = '0;
        foreach (ld_cyc[i]) if (ld_cyc[i] < slot_start) v = ld_val[i];
        return v;
    endfunction

    task automatic check_cycle(input int c);
        int p, d;
        logic [19:0] a;
        logic [3:0] n;
        logic [7:0] e_seg;
        logic [NUM_DIG-1:0] e_sel;
        logic hi_zero;
        p = c % TICK;
        d = (c / TICK) % NUM_DIG;
        a = act_for(c);
        if (p < BLANK_CYC) begin
            e_seg = 8'hFF;
            e_sel = '1;
        end else begin
            n = a[4*d +: 4];
            e_seg = {~a[16 + d], hex_tab[n][6:0]};
            e_sel = '1;
            e_sel[d] = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
            hi_zero = 1'b1;
            for (int j = d; j < NUM_DIG; j++) if (a[4*j +: 4] != 4'h0) hi_zero = 1'b0;
            if (d > 0 && hi_zero && !a[16 + d]) e_seg = 8'hFF;
`else
            hi_zero = 1'b0;
`endif
        end
        check_eq("seg_n", 32'(seg_n), 32'(e_seg));
        check_eq("sel_n", 32'(sel_n), 32'(e_sel));
        check_eq("frame_done", 32'(frame_done), 32'((p == TICK - 1) && (d == NUM_DIG - 1)));
    endtask

    // driver: one clock cycle with given load inputs, then check registered outputs
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp);
        load    = ld;
        data_in = d;
        dp_in   = dp;
        if (ld) begin
            ld_cyc.push_back(cyc);
            ld_val.push_back({dp, d});
        end
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        check_cycle(cyc);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic goto_pos(input int p);
        for (int i = 0; i < TICK && (cyc % TICK) != p; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_seg_n", 32'(seg_n), 32'h0000_00FF);
        check_eq("rst_sel_n", 32'(sel_n), 32'(4'hF));
        check_eq("rst_frame_done", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        ld_cyc.delete();
        ld_val.delete();
    endtask

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        data_in = '0;
        dp_in   = '0;
        cyc     = 0;
        do_reset();

        // idle frame: blank/show pattern on all four digits, one frame_done
        idle(45);

        // mid-slot load shows from the next boundary
        goto_pos(5);
        step(1'b1, 16'h12AF, 4'b0010);
        idle(50);

        // load on the boundary cycle itself
        goto_pos(9);
        step(1'b1, 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
        idle(12);

        // several loads in one slot: last wins
        goto_pos(2);
        step(1'b1, 16'h0001, 4'h0);
        step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h0002, 4'h0);
        step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h0003, 4'h0);
        idle(45);

        // hex sweep through digit 0
        for (int v = 0; v < 16; v++) begin
            step(1'b1, 16'(v), 4'h0);
            idle(40);
        end

        // leading-zero cases
        step(1'b1, 16'h0050, 4'h0);
        idle(45);
        step(1'b1, 16'h0000, 4'h0);
        idle(45);
        step(1'b1, 16'h0000, 4'b0100);
        idle(45);

        // random load traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                step(1'b1, 16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)));
            else
                step(1'b0, 16'($urandom_range(0, 65535)), 4'h0);
        end

        // asynchronous reset during SHOW of digit 2
        for (int i = 0; i < 4 * TICK && (cyc % (4 * TICK)) != 2 * TICK + 5; i++) step(1'b0, 16'h0, 4'h0);
        check_eq("pre_rst_sel_n", 32'(sel_n), 32'(4'b1011));
        do_reset();
        idle(45);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_drv.md
Name: seg7_scan_drv

Overview:
- Time-multiplexed driver for an NUM_DIG-digit common-anode seven-segment display.
- Consumes hex nibbles from the upstream debounced key counter: sum goes to data_in[3:0], key_flag goes to load.
- Double-buffers the display value, scans one digit per slot, and inserts an anti-ghosting blank gap at every digit change.
- Sits between the key/counter logic and the board's segment/select pins.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit slot rate in Hz. TICK = CLK_HZ/SCAN_HZ cycles per slot (integer division).
- NUM_DIG, 4, number of digits (1..8).
- BLANK_CYC, 500, blanked cycles at the start of each slot. Requires BLANK_CYC < TICK. 0 means no blanking.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- data_in, input, 4*NUM_DIG, hex value. Nibble i drives digit i; digit 0 is least significant.
- dp_in, input, NUM_DIG, decimal-point request per digit (1 = lit).
- load, input, 1, single-cycle strobe that captures data_in/dp_in.
- seg_n, output, 8, active-low segments {dp,g,f,e,d,c,b,a}.
- sel_n, output, NUM_DIG, active-low one-hot digit select.
- frame_done, output, 1, one-cycle pulse after the last digit slot of a frame.

Behaviour:
- Reset (async, all registers):
  - cnt=0, idx=0, pend=0, pend_valid=0, act=0 (value and dp).
  - seg_n=8'hFF, sel_n=all ones, frame_done=0.
- Prescaler cnt counts 0..TICK-1.
  - At cnt==TICK-1: cnt<=0 (slot boundary) and idx<=idx+1.
  - idx wraps from NUM_DIG-1 to 0.
- State per cycle:
  - BLANK when cnt<BLANK_CYC.
  - SHOW otherwise.
  - The first slot after reset starts in BLANK (cnt=0).
- Outputs are registered, 1-cycle latency from the (cnt, idx, act) of the previous cycle.
  - BLANK: sel_n=all ones, seg_n=8'hFF.
  - SHOW: sel_n has only bit idx low; seg_n = {~dp_act[idx], hex7(act nibble idx)}.
- hex7 encoding, active-low, bits g..a, shown with dp off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Load double-buffering:
  - load=1 writes data_in/dp_in into pend and sets pend_valid.
  - At a slot boundary with pend_valid=1: act<=pend, pend_valid<=0.
  - load in the same cycle as a boundary bypasses pend: act<=data_in directly, pend_valid<=0.
  - act never changes mid-slot.
  - Multiple loads within one slot: last one wins.
- frame_done: asserted for exactly one cycle, the cycle after the boundary where idx wraps NUM_DIG-1 to 0.
- Reset mid-slot: outputs blank immediately (async) and scanning restarts at digit 0, BLANK phase.

Optional Feature:
- Macro LEAD_ZERO_BLANK_EN.
- Defined: leading-zero suppression.
  - In SHOW, digit i>0 whose act nibble and all higher nibbles are 0 and whose dp is off outputs seg_n=8'hFF.
  - sel_n is still driven normally, so timing is unchanged.
  - Digit 0 is always shown.
- Undefined: all digits display their nibble, including leading zeros.

Test Plan (CLK_HZ=1000, SCAN_HZ=100 so TICK=10, BLANK_CYC=2, NUM_DIG=4):
- Reset then idle 40 cycles:
  - Slot 0: 2 cycles sel_n=1111 / seg_n=FF, then 8 cycles sel_n=1110 / seg_n=C0.
  - Slots 1..3 follow the same pattern with sel_n=1101, 1011, 0111.
  - frame_done pulses once after cycle 40.
- load with data_in=16'h12AF, dp_in=4'b0010, mid-slot:
  - The current slot is unchanged.
  - From the next boundary: digit0 seg_n=8E, digit1 seg_n=08 (A with dp lit), digit2 seg_n=A4, digit3 seg_n=F9.
- load exactly at cnt==9: the new value is visible in the very next slot's SHOW phase. Then 3 loads (1,2,3) in one slot: only 3 is displayed.
- Assert rst_n low during SHOW of digit 2: sel_n=1111 and seg_n=FF in the same cycle. After release, scanning restarts at digit 0 with act=0.
- LEAD_ZERO_BLANK_EN defined, data_in=16'h0050:
  - Digits 3 and 2 give seg_n=FF with their sel_n low.
  - Digit 1 gives 92, digit 0 gives C0.
  - data_in=0 shows only digit 0 = C0.
- Hex sweep: load 0..F sequentially into digit 0 and check every hex7 code against the table.
